// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - MIPS decode constants and the ID/EX control bundle type
package id_stage_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operation codes presented to EX
    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_ADDU = 6'd1;
    localparam logic [5:0] ALU_SUB  = 6'd2;
    localparam logic [5:0] ALU_SUBU = 6'd3;
    localparam logic [5:0] ALU_AND  = 6'd4;
    localparam logic [5:0] ALU_OR   = 6'd5;
    localparam logic [5:0] ALU_XOR  = 6'd6;
    localparam logic [5:0] ALU_NOR  = 6'd7;
    localparam logic [5:0] ALU_SLT  = 6'd8;
    localparam logic [5:0] ALU_SLTU = 6'd9;
    localparam logic [5:0] ALU_SLL  = 6'd10;
    localparam logic [5:0] ALU_SRL  = 6'd11;
    localparam logic [5:0] ALU_SRA  = 6'd12;

    // Width-independent control part of the ID/EX bundle
    typedef struct packed {
        logic [5:0] alu_op;
        logic [4:0] reg_w;
        logic [4:0] shamt;
        logic       reg_write_en;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } id_ex_t;

endpackage

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational MIPS instruction decoder
//   instr      : instruction word
//   ctrl       : control bundle (alu_op, dest, enables, illegal)
//   imm        : extended immediate (sign, zero or LUI form)
//   use_rt_b   : ALU operand B is rt_data rather than imm
//   zero_a     : ALU operand A is forced to 0 (LUI)
//   uses_rt    : instruction reads rt (hazard detection)
//   is_load, is_beq, is_bne, is_jump : class flags
module id_decoder
    import id_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output id_ex_t          ctrl,
    output logic [XLEN-1:0] imm,
    output logic            use_rt_b,
    output logic            zero_a,
    output logic            uses_rt,
    output logic            is_load,
    output logic            is_beq,
    output logic            is_bne,
    output logic            is_jump
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [XLEN-1:0] simm;
    logic [XLEN-1:0] zimm;
    logic [XLEN-1:0] limm;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign simm  = {{(XLEN-16){instr[15]}}, instr[15:0]};
    assign zimm  = {{(XLEN-16){1'b0}}, instr[15:0]};
    assign limm  = XLEN'({instr[15:0], 16'b0});

    always_comb begin
        logic wen;
        logic bad;
        logic [5:0] aop;
        wen      = 1'b0;
        bad      = 1'b0;
        aop      = ALU_ADD;
        imm      = simm;
        use_rt_b = 1'b0;
        zero_a   = 1'b0;
        uses_rt  = 1'b0;
        is_load  = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_jump  = 1'b0;
        ctrl.mem_read  = 1'b0;
        ctrl.mem_write = 1'b0;
        ctrl.reg_w     = rt;
        ctrl.shamt     = instr[10:6];

        case (op)
            OP_RTYPE: begin
                ctrl.reg_w = rd;
                use_rt_b   = 1'b1;
                uses_rt    = 1'b1;
                wen        = 1'b1;
                case (funct)
                    FN_ADD:  aop = ALU_ADD;
                    FN_ADDU: aop = ALU_ADDU;
                    FN_SUB:  aop = ALU_SUB;
                    FN_SUBU: aop = ALU_SUBU;
                    FN_AND:  aop = ALU_AND;
                    FN_OR:   aop = ALU_OR;
                    FN_XOR:  aop = ALU_XOR;
                    FN_NOR:  aop = ALU_NOR;
                    FN_SLT:  aop = ALU_SLT;
                    FN_SLTU: aop = ALU_SLTU;
                    FN_SLL:  aop = ALU_SLL;
                    FN_SRL:  aop = ALU_SRL;
                    FN_SRA:  aop = ALU_SRA;
                    default: bad = 1'b1;
                endcase
            end
            OP_ADDI:  begin aop = ALU_ADD;  wen = 1'b1; end
            OP_ADDIU: begin aop = ALU_ADDU; wen = 1'b1; end
            OP_SLTI:  begin aop = ALU_SLT;  wen = 1'b1; end
            OP_SLTIU: begin aop = ALU_SLTU; wen = 1'b1; end
            OP_ANDI:  begin aop = ALU_AND;  wen = 1'b1; imm = zimm; end
            OP_ORI:   begin aop = ALU_OR;   wen = 1'b1; imm = zimm; end
            OP_XORI:  begin aop = ALU_XOR;  wen = 1'b1; imm = zimm; end
            // LUI is executed as 0 + (imm << 16) so EX needs no extra op
            OP_LUI:   begin aop = ALU_ADD;  wen = 1'b1; imm = limm; zero_a = 1'b1; end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                wen           = 1'b1;
                is_load       = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                uses_rt        = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin aop = ALU_SUB; use_rt_b = 1'b1; uses_rt = 1'b1; is_beq = 1'b1; end
            OP_BNE: begin aop = ALU_SUB; use_rt_b = 1'b1; uses_rt = 1'b1; is_bne = 1'b1; end
            OP_J:   is_jump = 1'b1;
            default: bad = 1'b1;
        endcase

        // An illegal word must not cause any architectural side effect
        if (bad) begin
            wen            = 1'b0;
            aop            = ALU_ADD;
            uses_rt        = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
        end

        ctrl.alu_op       = aop;
        ctrl.illegal      = bad;
        ctrl.reg_write_en = wen && (ctrl.reg_w != 5'd0);
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - pipelined MIPS decode stage with load-use stall and branch resolve
//   clk, rst_n                : clock, async active-low reset
//   in_valid/in_ready/in_instr/in_pc : fetch side handshake and instruction
//   rs_data, rt_data          : register file reads for the presented instruction
//   out_valid/out_ready       : EX side handshake
//   out_alu_a .. out_illegal  : registered ID/EX bundle
//   branch_taken/branch_target: registered redirect, qualified by out_valid
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [XLEN-1:0]   rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_alu_a,
    output logic [XLEN-1:0]   out_alu_b,
    output logic [XLEN-1:0]   out_store_data,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_alu_op,
    output logic [REG_AW-1:0] out_reg_w,
    output logic              out_reg_write_en,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_illegal,
    output logic              branch_taken,
    output logic [XLEN-1:0]   branch_target
);

    localparam logic [1:0] STALLS = 2'(LOAD_USE_STALLS);

    id_ex_t          dec;
    logic [XLEN-1:0] imm;
    logic            use_rt_b;
    logic            zero_a;
    logic            uses_rt;
    logic            is_load;
    logic            is_beq;
    logic            is_bne;
    logic            is_jump;

    id_decoder #(.XLEN(XLEN)) u_dec (
        .instr    (in_instr),
        .ctrl     (dec),
        .imm      (imm),
        .use_rt_b (use_rt_b),
        .zero_a   (zero_a),
        .uses_rt  (uses_rt),
        .is_load  (is_load),
        .is_beq   (is_beq),
        .is_bne   (is_bne),
        .is_jump  (is_jump)
    );

    logic [1:0] stall_cnt;
    logic [4:0] pend_reg;
    logic       adv;
    logic       hazard;
    logic       accept;

    assign adv    = !out_valid || out_ready;
    assign hazard = (stall_cnt != 2'd0) && (pend_reg != 5'd0) && in_valid &&
                    ((in_instr[25:21] == pend_reg) ||
                     (uses_rt && (in_instr[20:16] == pend_reg)));
    assign in_ready = adv && !hazard;
    assign accept   = in_valid && in_ready;

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] j_target;
    logic [XLEN-1:0] b_target;
    logic            taken_next;

    assign pc4        = in_pc + XLEN'(4);
    assign j_target   = {pc4[XLEN-1:28], in_instr[25:0], 2'b00};
    assign b_target   = pc4 + (imm << 2);
    assign taken_next = is_jump || (is_beq && (rs_data == rt_data)) ||
                        (is_bne && (rs_data != rt_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_alu_a        <= '0;
            out_alu_b        <= '0;
            out_store_data   <= '0;
            out_shamt        <= '0;
            out_alu_op       <= '0;
            out_reg_w        <= '0;
            out_reg_write_en <= 1'b0;
            out_mem_read     <= 1'b0;
            out_mem_write    <= 1'b0;
            out_illegal      <= 1'b0;
            branch_taken     <= 1'b0;
            branch_target    <= '0;
        end else if (adv) begin
            out_valid <= accept;
            if (accept) begin
                out_alu_a        <= zero_a ? '0 : rs_data;
                out_alu_b        <= use_rt_b ? rt_data : imm;
                out_store_data   <= rt_data;
                out_shamt        <= dec.shamt;
                out_alu_op       <= dec.alu_op;
                out_reg_w        <= REG_AW'(dec.reg_w);
                out_reg_write_en <= dec.reg_write_en;
                out_mem_read     <= dec.mem_read;
                out_mem_write    <= dec.mem_write;
                out_illegal      <= dec.illegal;
                branch_taken     <= taken_next;
                branch_target    <= is_jump ? j_target : b_target;
            end else begin
                // Bubble: data fields keep their last value, every enable drops
                out_reg_write_en <= 1'b0;
                out_mem_read     <= 1'b0;
                out_mem_write    <= 1'b0;
                out_illegal      <= 1'b0;
                branch_taken     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 2'd0;
            pend_reg  <= 5'd0;
        end else if (accept && is_load) begin
            stall_cnt <= STALLS;
            pend_reg  <= dec.reg_w;
        end else if (adv && (stall_cnt != 2'd0)) begin
            stall_cnt <= stall_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_ready;

    logic        in_ready_1, out_valid_1, wen_1, mrd_1, mwr_1, ill_1, tk_1;
    logic [31:0] a_1, b_1, sd_1, tgt_1;
    logic [4:0]  sh_1, rw_1;
    logic [5:0]  op_1;

    logic        in_ready_2, out_valid_2, wen_2, mrd_2, mwr_2, ill_2, tk_2;
    logic [31:0] a_2, b_2, sd_2, tgt_2;
    logic [4:0]  sh_2, rw_2;
    logic [5:0]  op_2;

    int n_vec = 0;
    int n_err = 0;

    id_stage #(.XLEN(32), .REG_AW(5), .LOAD_USE_STALLS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
        .in_instr(in_instr), .in_pc(in_pc), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid_1), .out_ready(out_ready), .out_alu_a(a_1), .out_alu_b(b_1),
        .out_store_data(sd_1), .out_shamt(sh_1), .out_alu_op(op_1), .out_reg_w(rw_1),
        .out_reg_write_en(wen_1), .out_mem_read(mrd_1), .out_mem_write(mwr_1),
        .out_illegal(ill_1), .branch_taken(tk_1), .branch_target(tgt_1)
    );

    id_stage #(.XLEN(32), .REG_AW(5), .LOAD_USE_STALLS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_2),
        .in_instr(in_instr), .in_pc(in_pc), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid_2), .out_ready(out_ready), .out_alu_a(a_2), .out_alu_b(b_2),
        .out_store_data(sd_2), .out_shamt(sh_2), .out_alu_op(op_2), .out_reg_w(rw_2),
        .out_reg_write_en(wen_2), .out_mem_read(mrd_2), .out_mem_write(mwr_2),
        .out_illegal(ill_2), .branch_taken(tk_2), .branch_target(tgt_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        in_valid = 1'b1;
        in_instr = instr;
        rs_data  = rs;
        rt_data  = rt;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    localparam logic [31:0] I_ADDI_M1  = 32'h2008FFFF;
    localparam logic [31:0] I_ORI      = 32'h3408FFFF;
    localparam logic [31:0] I_LW_T0    = 32'h8FA80000;
    localparam logic [31:0] I_ADD_T1   = 32'h01084820;
    localparam logic [31:0] I_ADDI_T2  = 32'h200A0005;
    localparam logic [31:0] I_BEQ      = 32'h10220004;
    localparam logic [31:0] I_BNE      = 32'h14220004;
    localparam logic [31:0] I_J        = 32'h08100000;
    localparam logic [31:0] I_ILLEGAL  = 32'hFC000000;
    localparam logic [31:0] I_ADDU_Z   = 32'h01090021;
    localparam logic [31:0] I_SW       = 32'hAFA90004;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h00400000;
        rs_data   = 32'h0;
        rt_data   = 32'h0;
        out_ready = 1'b1;

        #2;
        check("rst_out_valid", 32'(out_valid_1), 32'd0);
        check("rst_taken",     32'(tk_1),        32'd0);
        check("rst_illegal",   32'(ill_1),       32'd0);
        check("rst_wen",       32'(wen_1),       32'd0);
        check("rst_alu_b",     b_1,              32'd0);
        rst_n = 1'b1;
        tick();

        // Plain decode
        drive(I_ADDI_M1, 32'h0, 32'h0);
        tick();
        check("addi_valid",  32'(out_valid_1), 32'd1);
        check("addi_alu_b",  b_1,              32'hFFFFFFFF);
        check("addi_reg_w",  32'(rw_1),        32'd8);
        check("addi_wen",    32'(wen_1),       32'd1);
        check("addi_alu_op", 32'(op_1),        32'(ALU_ADD));
        drive(I_ORI, 32'h0, 32'h0);
        tick();
        check("ori_alu_b",   b_1,              32'h0000FFFF);
        check("ori_alu_op",  32'(op_1),        32'(ALU_OR));

        // Load-use, one bubble
        drive(I_LW_T0, 32'h1000, 32'h0);
        tick();
        check("lw_mem_read", 32'(mrd_1), 32'd1);
        check("lw_wen",      32'(wen_1), 32'd1);
        drive(I_ADD_T1, 32'h7, 32'h7);
        check("lu_in_ready_low", 32'(in_ready_1), 32'd0);
        tick();
        check("lu_bubble",        32'(out_valid_1), 32'd0);
        check("lu_in_ready_high", 32'(in_ready_1),  32'd1);
        tick();
        check("lu_add_valid", 32'(out_valid_1), 32'd1);
        check("lu_add_reg_w", 32'(rw_1),        32'd9);

        // Load followed by an independent instruction
        drive(I_LW_T0, 32'h1000, 32'h0);
        tick();
        drive(I_ADDI_T2, 32'h0, 32'h0);
        check("indep_in_ready", 32'(in_ready_1), 32'd1);
        tick();
        check("indep_valid", 32'(out_valid_1), 32'd1);
        check("indep_reg_w", 32'(rw_1),        32'd10);

        // Backpressure
        drive(I_ADD_T1, 32'h3, 32'h4);
        tick();
        out_ready = 1'b0;
        drive(I_ORI, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 32'(in_ready_1),  32'd0);
            check("bp_valid",    32'(out_valid_1), 32'd1);
            check("bp_reg_w",    32'(rw_1),        32'd9);
            check("bp_alu_a",    a_1,              32'h3);
            check("bp_alu_b",    b_1,              32'h4);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready_1), 32'd1);
        tick();
        check("bp_next_reg_w", 32'(rw_1), 32'd8);
        check("bp_next_alu_b", b_1,       32'h0000FFFF);
        in_valid = 1'b0;
        tick();
        check("bp_no_dup", 32'(out_valid_1), 32'd0);

        // Branches
        in_pc = 32'h00400000;
        drive(I_BEQ, 32'd5, 32'd5);
        tick();
        check("beq_taken",  32'(tk_1), 32'd1);
        check("beq_target", tgt_1,     32'h00400014);
        drive(I_BNE, 32'd5, 32'd5);
        tick();
        check("bne_taken",  32'(tk_1), 32'd0);
        drive(I_J, 32'd0, 32'd0);
        tick();
        check("j_taken",  32'(tk_1), 32'd1);
        check("j_target", tgt_1,     32'h00400000);

        // Illegal, $zero destination, store
        drive(I_ILLEGAL, 32'd1, 32'd2);
        tick();
        check("ill_flag",   32'(ill_1), 32'd1);
        check("ill_wen",    32'(wen_1), 32'd0);
        check("ill_mrd",    32'(mrd_1), 32'd0);
        check("ill_mwr",    32'(mwr_1), 32'd0);
        check("ill_alu_op", 32'(op_1),  32'(ALU_ADD));
        check("ill_taken",  32'(tk_1),  32'd0);
        drive(I_ADDU_Z, 32'd1, 32'd2);
        tick();
        check("zero_wen",   32'(wen_1), 32'd0);
        check("zero_legal", 32'(ill_1), 32'd0);
        drive(I_SW, 32'h1000, 32'hCAFE0001);
        tick();
        check("sw_mwr",  32'(mwr_1), 32'd1);
        check("sw_wen",  32'(wen_1), 32'd0);
        check("sw_data", sd_1,       32'hCAFE0001);
        check("sw_alu_b", b_1,       32'h00000004);
        in_valid = 1'b0;

        // Two-bubble configuration
        do_reset();
        drive(I_LW_T0, 32'h1000, 32'h0);
        check("lu2_lw_ready", 32'(in_ready_2), 32'd1);
        tick();
        drive(I_ADD_T1, 32'h7, 32'h7);
        check("lu2_ready_0", 32'(in_ready_2), 32'd0);
        tick();
        check("lu2_bubble_1", 32'(out_valid_2), 32'd0);
        check("lu2_ready_1",  32'(in_ready_2),  32'd0);
        tick();
        check("lu2_bubble_2", 32'(out_valid_2), 32'd0);
        check("lu2_ready_2",  32'(in_ready_2),  32'd1);
        tick();
        check("lu2_add_valid", 32'(out_valid_2), 32'd1);
        check("lu2_add_reg_w", 32'(rw_2),        32'd9);
        in_valid = 1'b0;

        // Asynchronous reset in the middle of a stall
        do_reset();
        drive(I_LW_T0, 32'h1000, 32'h0);
        tick();
        drive(I_ADD_T1, 32'h7, 32'h7);
        check("rs_stall_ready", 32'(in_ready_1), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rs_async_valid", 32'(out_valid_1), 32'd0);
        check("rs_async_mrd",   32'(mrd_1),       32'd0);
        check("rs_async_wen",   32'(wen_1),       32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("rs_after_ready", 32'(in_ready_1), 32'd1);
        tick();
        check("rs_add_valid", 32'(out_valid_1), 32'd1);
        check("rs_add_reg_w", 32'(rw_1),        32'd9);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
